adc_multi_range_acq: RTL

Parametrised successor to the two-channel ADC range/result sequencer. It generalises channel count, sample width, averaging depths and settle time, and adds an end-of-cycle valid strobe and a busy-timeout error. On a start edge it runs a range-finding (diapason) phase of 2^DIAP_LOG2 conversions and picks a per-channel range code from peak |sample|. It then settles and runs a result phase of 2^RES_LOG2 conversions, averaging signed samples per channel. It sits between the ADC convert/busy pins plus an external SPI master, and the downstream data logger.

---
 rtl/adc_multi_range_acq_if.sv | 29 ++
 rtl/adc_multi_range_acq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_multi_range_acq_if.sv
// Bundle of the acquisition signals: ADC pins, SPI master handshake and logger-side results.
interface adc_multi_range_acq_if #(
    parameter int CH_COUNT   = 2,
    parameter int CH_WIDTH   = 18,
    parameter int DATA_WIDTH = 24,
    parameter int DIAP_WIDTH = 2
);
    logic                           start_cycle_conv;
    logic                           adc_busy;
    logic                           adc_cnv;
    logic                           spi_start;
    logic                           spi_new_data;
    logic [CH_COUNT*CH_WIDTH-1:0]   spi_data;
    logic                           complete;
    logic                           data_valid;
    logic [CH_COUNT*DATA_WIDTH-1:0] data_out;
    logic [CH_COUNT*DIAP_WIDTH-1:0] diap;
    logic                           timeout_err;

    modport master (
        input  start_cycle_conv, adc_busy, spi_new_data, spi_data,
        output adc_cnv, spi_start, complete, data_valid, data_out, diap, timeout_err
    );

    modport slave (
        output start_cycle_conv, adc_busy, spi_new_data, spi_data,
        input  adc_cnv, spi_start, complete, data_valid, data_out, diap, timeout_err
    );
endinterface

// File: rtl/adc_multi_range_acq.sv
// Multi-channel ADC sequencer: range-finding phase picks a per-channel range code from
// peak |sample|, optional settle, then a result phase averages signed samples per channel.
module adc_multi_range_acq #(
    parameter int CH_COUNT       = 2,
    parameter int CH_WIDTH       = 18,
    parameter int DATA_WIDTH     = 24,
    parameter int DIAP_WIDTH     = 2,
    parameter int DIAP_LOG2      = 6,
    parameter int RES_LOG2       = 10,
    parameter int SETTLE_CYCLES  = 256,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    adc_multi_range_acq_if.master bus
);
    localparam int ACC_W   = CH_WIDTH + RES_LOG2;
    localparam int CNT_W   = ((DIAP_LOG2 > RES_LOG2) ? DIAP_LOG2 : RES_LOG2) + 1;
    localparam int TMR_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;

    localparam logic [CNT_W-1:0] DIAP_LAST   = CNT_W'(2**DIAP_LOG2 - 1);
    localparam logic [CNT_W-1:0] RES_LAST    = CNT_W'(2**RES_LOG2 - 1);
    localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);

    localparam logic [CH_WIDTH-1:0] TH_CODE0 = CH_WIDTH'(2**(CH_WIDTH-2));
    localparam logic [CH_WIDTH-1:0] TH_CODE1 = CH_WIDTH'(2**(CH_WIDTH-4));
    localparam logic [CH_WIDTH-1:0] TH_CODE2 = CH_WIDTH'(2**(CH_WIDTH-6));
    localparam logic [CH_WIDTH-1:0] ONE_CW   = CH_WIDTH'(1);

    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_D_CNV       = 4'd1;
    localparam logic [3:0] S_D_WAIT_BUSY = 4'd2;
    localparam logic [3:0] S_D_SPI       = 4'd3;
    localparam logic [3:0] S_D_WAIT_SPI  = 4'd4;
    localparam logic [3:0] S_D_ACC       = 4'd5;
    localparam logic [3:0] S_CHOOSE      = 4'd6;
    localparam logic [3:0] S_SETTLE      = 4'd7;
    localparam logic [3:0] S_R_CNV       = 4'd8;
    localparam logic [3:0] S_R_WAIT_BUSY = 4'd9;
    localparam logic [3:0] S_R_SPI       = 4'd10;
    localparam logic [3:0] S_R_WAIT_SPI  = 4'd11;
    localparam logic [3:0] S_R_ACC       = 4'd12;
    localparam logic [3:0] S_DONE        = 4'd13;

    // Magnitude of a two's-complement sample; the most negative code maps to 2^(W-1) unsigned.
    function automatic logic [CH_WIDTH-1:0] abs_mag(input logic [CH_WIDTH-1:0] s);
        return s[CH_WIDTH-1] ? (~s + ONE_CW) : s;
    endfunction

    // Range code from peak magnitude: larger peaks get the lower (coarser) code.
    function automatic logic [DIAP_WIDTH-1:0] range_code(input logic [CH_WIDTH-1:0] pk);
        if (pk >= TH_CODE0)      return DIAP_WIDTH'(0);
        else if (pk >= TH_CODE1) return DIAP_WIDTH'(1);
        else if (pk >= TH_CODE2) return DIAP_WIDTH'(2);
        else                     return DIAP_WIDTH'(3);
    endfunction

    // Sign-extend a raw sample to accumulator width.
    function automatic logic signed [ACC_W-1:0] sext_samp(input logic [CH_WIDTH-1:0] s);
        return {{RES_LOG2{s[CH_WIDTH-1]}}, s};
    endfunction

    // Sign-extend or truncate the shifted mean to the output width.
    function automatic logic [DATA_WIDTH-1:0] fit_out(input logic signed [ACC_W-1:0] v);
        logic [ACC_W+DATA_WIDTH-1:0] w;
        w = {{DATA_WIDTH{v[ACC_W-1]}}, v};
        return w[DATA_WIDTH-1:0];
    endfunction

    logic start_s1_q, start_s2_q, busy_s1_q, busy_s2_q;
    logic start_rise, busy_fall;

    logic [3:0]                     state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [TMR_W-1:0]               tmr_q, tmr_d;
    logic [CH_COUNT*CH_WIDTH-1:0]   samp_q, samp_d;
    logic [CH_WIDTH-1:0]            peak_q [CH_COUNT];
    logic [CH_WIDTH-1:0]            peak_d [CH_COUNT];
    logic signed [ACC_W-1:0]        acc_q  [CH_COUNT];
    logic signed [ACC_W-1:0]        acc_d  [CH_COUNT];
    logic [CH_COUNT*DIAP_WIDTH-1:0] diap_q, diap_d;
    logic [CH_COUNT*DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic data_valid_q, data_valid_d;
    logic adc_cnv_q, adc_cnv_d;
    logic spi_start_q, spi_start_d;
    logic complete_q, complete_d;
    logic timeout_err_q, timeout_err_d;
    logic [CH_WIDTH-1:0] mag;

    // Two-flop synchronisers for the asynchronous start and busy pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_s1_q <= 1'b0;
            start_s2_q <= 1'b0;
            busy_s1_q  <= 1'b0;
            busy_s2_q  <= 1'b0;
        end else begin
            start_s1_q <= bus.start_cycle_conv;
            start_s2_q <= start_s1_q;
            busy_s1_q  <= bus.adc_busy;
            busy_s2_q  <= busy_s1_q;
        end
    end

    assign start_rise = start_s1_q & ~start_s2_q;
    assign busy_fall  = ~busy_s1_q & busy_s2_q;

    // Sequencer next-state, datapath updates and registered output decode.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tmr_d         = tmr_q;
        samp_d        = samp_q;
        peak_d        = peak_q;
        acc_d         = acc_q;
        diap_d        = diap_q;
        data_out_d    = data_out_q;
        data_valid_d  = 1'b0;
        timeout_err_d = timeout_err_q;
        mag           = '0;

        case (state_q)
            S_IDLE: begin
                if (start_rise) begin
                    for (int i = 0; i < CH_COUNT; i++) begin
                        peak_d[i] = '0;
                        acc_d[i]  = '0;
                    end
                    cnt_d         = '0;
                    timeout_err_d = 1'b0;
                    state_d       = S_D_CNV;
                end
            end
            S_D_CNV, S_R_CNV: begin
                tmr_d   = '0;
                state_d = (state_q == S_D_CNV) ? S_D_WAIT_BUSY : S_R_WAIT_BUSY;
            end
            S_D_WAIT_BUSY, S_R_WAIT_BUSY: begin
                if (busy_fall) begin
                    state_d = (state_q == S_D_WAIT_BUSY) ? S_D_SPI : S_R_SPI;
                end else if (tmr_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_D_SPI, S_R_SPI: begin
                tmr_d   = '0;
                state_d = (state_q == S_D_SPI) ? S_D_WAIT_SPI : S_R_WAIT_SPI;
            end
            S_D_WAIT_SPI, S_R_WAIT_SPI: begin
                if (bus.spi_new_data) begin
                    samp_d  = bus.spi_data;
                    state_d = (state_q == S_D_WAIT_SPI) ? S_D_ACC : S_R_ACC;
                end else if (tmr_q == TMO_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_D_ACC: begin
                for (int i = 0; i < CH_COUNT; i++) begin
                    mag = abs_mag(samp_q[i*CH_WIDTH +: CH_WIDTH]);
                    if (mag > peak_q[i]) peak_d[i] = mag;
                end
                if (cnt_q == DIAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_CHOOSE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_D_CNV;
                end
            end
            S_CHOOSE: begin
                for (int i = 0; i < CH_COUNT; i++) begin
                    diap_d[i*DIAP_WIDTH +: DIAP_WIDTH] = range_code(peak_q[i]);
                end
                // A range change needs the analog front end to settle before results.
                tmr_d   = '0;
                state_d = (diap_d != diap_q) ? S_SETTLE : S_R_CNV;
            end
            S_SETTLE: begin
                if (tmr_q == SETTLE_LAST) state_d = S_R_CNV;
                else                      tmr_d   = tmr_q + TMR_W'(1);
            end
            S_R_ACC: begin
                for (int i = 0; i < CH_COUNT; i++) begin
                    acc_d[i] = acc_q[i] + sext_samp(samp_q[i*CH_WIDTH +: CH_WIDTH]);
                end
                if (cnt_q == RES_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_R_CNV;
                end
            end
            S_DONE: begin
                for (int i = 0; i < CH_COUNT; i++) begin
                    data_out_d[i*DATA_WIDTH +: DATA_WIDTH] = fit_out(acc_q[i] >>> RES_LOG2);
                end
                data_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        adc_cnv_d   = (state_d == S_D_CNV) || (state_d == S_R_CNV);
        spi_start_d = (state_d == S_D_SPI) || (state_d == S_R_SPI);
        complete_d  = (state_d == S_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            tmr_q         <= '0;
            samp_q        <= '0;
            for (int i = 0; i < CH_COUNT; i++) begin
                peak_q[i] <= '0;
                acc_q[i]  <= '0;
            end
            diap_q        <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            adc_cnv_q     <= 1'b0;
            spi_start_q   <= 1'b0;
            complete_q    <= 1'b1;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tmr_q         <= tmr_d;
            samp_q        <= samp_d;
            peak_q        <= peak_d;
            acc_q         <= acc_d;
            diap_q        <= diap_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            adc_cnv_q     <= adc_cnv_d;
            spi_start_q   <= spi_start_d;
            complete_q    <= complete_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.adc_cnv     = adc_cnv_q;
    assign bus.spi_start   = spi_start_q;
    assign bus.complete    = complete_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.data_out    = data_out_q;
    assign bus.diap        = diap_q;
    assign bus.timeout_err = timeout_err_q;
endmodule
